// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: sequential word fetch into an in-order PC-tagged buffer with redirect flush
module instruction_fetch_unit #(
  parameter int DEPTH = 4,
  parameter logic [31:0] RESET_ADDR = 32'h00003000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:2] redirect_addr,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:2] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:2] inst_pc
);
  localparam int AW = $clog2(DEPTH);
  logic [31:2] fetch_q, fetch_d;
  logic [AW-1:0] head_q, head_d, fill_q, fill_d, tail_q, tail_d;
  logic [AW:0] used_q, used_d, filled_q, filled_d, drop_q, drop_d, unfilled;
  logic [31:2] pc_q [DEPTH];
  logic [31:0] data_q [DEPTH];
  logic req_fire, resp_fill, resp_drop, pop;
  assign unfilled = used_q - filled_q;
  assign imem_req_valid = !reset && !redirect_valid && ({1'b0, used_q} + {1'b0, drop_q} < (AW+2)'(DEPTH));
  assign imem_req_addr = fetch_q;
  assign req_fire = imem_req_valid && imem_req_ready;
  assign resp_drop = imem_resp_valid && drop_q != '0;
  assign resp_fill = imem_resp_valid && drop_q == '0 && unfilled != '0;
  assign inst_valid = !reset && filled_q != '0;
  assign pop = inst_valid && inst_ready;
  assign inst_data = inst_valid ? data_q[head_q] : '0;
  assign inst_pc = inst_valid ? pc_q[head_q] : '0;
  always_comb begin
    fetch_d = req_fire ? fetch_q + 30'd1 : fetch_q;
    head_d = pop ? head_q + AW'(1) : head_q;
    fill_d = resp_fill ? fill_q + AW'(1) : fill_q;
    tail_d = req_fire ? tail_q + AW'(1) : tail_q;
    used_d = used_q + (AW+1)'(req_fire) - (AW+1)'(pop);
    filled_d = filled_q + (AW+1)'(resp_fill) - (AW+1)'(pop);
    drop_d = resp_drop ? drop_q - (AW+1)'(1) : drop_q;
    if (redirect_valid) begin
      fetch_d = redirect_addr;
      head_d = '0;
      fill_d = '0;
      tail_d = '0;
      used_d = '0;
      filled_d = '0;
      drop_d = drop_q + unfilled - (AW+1)'(resp_drop || resp_fill);
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_q <= RESET_ADDR[31:2];
      head_q <= '0;
      fill_q <= '0;
      tail_q <= '0;
      used_q <= '0;
      filled_q <= '0;
      drop_q <= '0;
    end else begin
      fetch_q <= fetch_d;
      head_q <= head_d;
      fill_q <= fill_d;
      tail_q <= tail_d;
      used_q <= used_d;
      filled_q <= filled_d;
      drop_q <= drop_d;
    end
  end
  always_ff @(posedge clock) begin
    if (req_fire) pc_q[tail_q] <= fetch_q;
    if (resp_fill) data_q[fill_q] <= imem_resp_data;
  end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: queue-level fetch model with latency memory and directed scenarios
module tb_instruction_fetch_unit;
  localparam int DEPTH = 4;
  logic clock = 0, reset, redirect_valid, imem_req_valid, imem_req_ready;
  logic imem_resp_valid, inst_valid, inst_ready;
  logic [31:2] redirect_addr, imem_req_addr, inst_pc;
  logic [31:0] imem_resp_data, inst_data;
  instruction_fetch_unit #(.DEPTH(DEPTH), .RESET_ADDR(32'h00003000)) dut (
    .clock(clock), .reset(reset), .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc)
  );
  always #5 clock = ~clock;
  typedef struct {logic [29:0] a; int due;} pend_t;
  pend_t pend[$];
  logic [29:0] inflight[$];
  logic [61:0] rdy[$];
  logic [29:0] fa, first_pc, stale_lo, stale_hi;
  int drop = 0, checks = 0, failures = 0, cyc = 0, lat = 1, fires = 0, pops = 0, stale = 0;
  bit mem_en = 1, got_first = 0;
  function automatic logic [31:0] dfun(logic [29:0] a);
    return {a, 2'b11} ^ 32'h5A5A_0000;
  endfunction
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h cyc=%0d", n, act, exp, cyc);
    end
  endtask
  task automatic step();
    logic e_rv, e_iv, c_fire, c_rv, c_pop;
    logic [29:0] c_addr, p;
    if (mem_en && pend.size() > 0 && pend[0].due <= cyc) begin
      imem_resp_valid = 1;
      imem_resp_data = dfun(pend[0].a);
    end else begin
      imem_resp_valid = 0;
      imem_resp_data = '0;
    end
    #1;
    e_rv = !reset && !redirect_valid && (inflight.size() + rdy.size() + drop < DEPTH);
    e_iv = !reset && rdy.size() > 0;
    chk("req_valid", imem_req_valid, e_rv);
    if (e_rv) chk("req_addr", imem_req_addr, fa);
    chk("inst_valid", inst_valid, e_iv);
    if (e_iv) begin
      chk("inst_pc", inst_pc, rdy[0][61:32]);
      chk("inst_data", inst_data, rdy[0][31:0]);
    end else if (reset) begin
      chk("rst_inst_data", inst_data, 0);
      chk("rst_inst_pc", inst_pc, 0);
    end
    if (inst_valid && !got_first) begin
      got_first = 1;
      first_pc = inst_pc;
    end
    if (inst_valid && inst_pc >= stale_lo && inst_pc <= stale_hi) stale++;
    if (inst_valid && inst_ready) pops++;
    c_fire = imem_req_valid && imem_req_ready;
    c_addr = imem_req_addr;
    c_rv = imem_resp_valid;
    c_pop = e_iv && inst_ready;
    @(posedge clock);
    if (reset) pend.delete();
    else begin
      if (c_rv) void'(pend.pop_front());
      if (c_fire) begin
        pend.push_back('{c_addr, cyc + lat});
        fires++;
      end
    end
    if (reset) begin
      fa = 30'hC00;
      inflight.delete();
      rdy.delete();
      drop = 0;
    end else if (redirect_valid) begin
      drop = drop + inflight.size() - ((c_rv && (drop > 0 || inflight.size() > 0)) ? 1 : 0);
      inflight.delete();
      rdy.delete();
      fa = redirect_addr;
    end else begin
      if (c_pop) void'(rdy.pop_front());
      if (c_rv) begin
        if (drop > 0) drop--;
        else if (inflight.size() > 0) begin
          p = inflight.pop_front();
          rdy.push_back({p, dfun(p)});
        end
      end
      if (e_rv && imem_req_ready) begin
        inflight.push_back(fa);
        fa = fa + 30'd1;
      end
    end
    #1;
    cyc++;
  endtask
  task automatic run(int n);
    repeat (n) step();
  endtask
  initial begin
    reset = 1; redirect_valid = 0; redirect_addr = '0; imem_req_ready = 1; inst_ready = 1;
    imem_resp_valid = 0; imem_resp_data = '0; stale_lo = 30'h1; stale_hi = 30'h0;
    run(2);
    reset = 0;
    #1;
    chk("p1_first_valid", imem_req_valid, 1);
    chk("p1_first_addr", imem_req_addr, 30'hC00);
    run(2);
    chk("p1_first_inst_valid", inst_valid, 1);
    chk("p1_first_pc", inst_pc, 30'hC00);
    chk("p1_first_data", inst_data, 32'h5A5A3003);
    pops = 0;
    run(8);
    chk("p1_throughput", pops, 8);
    reset = 1; run(1); reset = 0;
    inst_ready = 0; fires = 0;
    run(8);
    chk("p2_accepted", fires, 4);
    chk("p2_req_blocked", imem_req_valid, 0);
    chk("p2_head_pc", inst_pc, 30'hC00);
    inst_ready = 1;
    run(1);
    chk("p2_resume_valid", imem_req_valid, 1);
    chk("p2_resume_addr", imem_req_addr, 30'hC04);
    run(8);
    reset = 1; run(1); reset = 0;
    inst_ready = 0; mem_en = 0;
    run(3);
    imem_req_ready = 0; mem_en = 1;
    run(1);
    mem_en = 0;
    redirect_valid = 1; redirect_addr = 30'h1000; imem_req_ready = 1; inst_ready = 1;
    run(1);
    redirect_valid = 0;
    #1;
    chk("p3_no_inst", inst_valid, 0);
    chk("p3_redir_addr", imem_req_addr, 30'h1000);
    got_first = 0; stale = 0; stale_lo = 30'hC00; stale_hi = 30'hC03; fires = 0;
    run(6);
    chk("p3_drop_two", fires, 2);
    mem_en = 1;
    run(10);
    chk("p3_first_pc", first_pc, 30'h1000);
    chk("p3_stale", stale, 0);
    reset = 1; run(1); reset = 0;
    inst_ready = 0; mem_en = 0;
    run(3);
    imem_req_ready = 0; mem_en = 1;
    run(1);
    redirect_valid = 1; redirect_addr = 30'h2000; imem_req_ready = 1; inst_ready = 1;
    run(1);
    redirect_valid = 0; mem_en = 0;
    #1;
    chk("p4_no_inst", inst_valid, 0);
    got_first = 0; stale = 0; fires = 0;
    run(6);
    chk("p4_drop_one", fires, 3);
    mem_en = 1;
    run(10);
    chk("p4_first_pc", first_pc, 30'h2000);
    chk("p4_stale", stale, 0);
    redirect_valid = 1; redirect_addr = 30'h3FFFFFFF;
    run(1);
    redirect_valid = 0;
    #1;
    chk("p5_addr_max", imem_req_addr, 30'h3FFFFFFF);
    run(1);
    chk("p5_wrap", imem_req_addr, 30'h0);
    run(5);
    inst_ready = 0;
    run(8);
    chk("p6_full_valid", inst_valid, 1);
    chk("p6_full_blocked", imem_req_valid, 0);
    reset = 1;
    run(1);
    chk("p6_rst_inst_valid", inst_valid, 0);
    chk("p6_rst_req_valid", imem_req_valid, 0);
    reset = 0;
    #1;
    chk("p6_restart_valid", imem_req_valid, 1);
    chk("p6_restart_addr", imem_req_addr, 30'hC00);
    inst_ready = 1;
    run(10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
